// File: rtl/twobit_26x18_mesh_pkg.sv
// Shared geometry, pixel type and torus neighbour index helpers for the 26x18 two-bit mesh.
package twobit_26x18_mesh_pkg;

    localparam int COLS  = 26;
    localparam int ROWS  = 18;
    localparam int PIX_W = 2;
    localparam int N_PIX = COLS * ROWS;
    localparam int ROW_W = 5;
    localparam int DEPTH = 4;

    typedef logic [PIX_W-1:0] pix_t;

    // Vertical neighbours wrap across the whole frame; horizontal ones wrap within the row.
    function automatic int idx_n(input int p);
        return (p + N_PIX - COLS) % N_PIX;
    endfunction

    function automatic int idx_s(input int p);
        return (p + COLS) % N_PIX;
    endfunction

    function automatic int idx_e(input int p);
        return (p / COLS) * COLS + ((p % COLS) + 1) % COLS;
    endfunction

    function automatic int idx_w(input int p);
        return (p / COLS) * COLS + ((p % COLS) + COLS - 1) % COLS;
    endfunction

endpackage

// File: rtl/twobit_26x18_mesh_if.sv
// Row-load / compute-control bundle and per-pixel result flags of the mesh.
interface twobit_26x18_mesh_if;
    import twobit_26x18_mesh_pkg::*;

    logic [COLS*PIX_W-1:0] inp;
    logic [ROW_W-1:0]      row;
    logic                  high;
    logic [N_PIX-1:0]      out;
    logic                  out_valid;

    modport master (
        output inp,
        output row,
        output high,
        input  out,
        input  out_valid
    );

    modport slave (
        input  inp,
        input  row,
        input  high,
        output out,
        output out_valid
    );

endinterface

// File: rtl/mesh_cell.sv
// Per-pixel "not below any neighbour" compare: MSB stage on en_msb, LSB resolve on en_lsb.
// Two registered stages; no backpressure, stages advance only on their enables.
module mesh_cell
    import twobit_26x18_mesh_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic en_msb,
    input  logic en_lsb,
    input  pix_t own,
    input  pix_t nbr_n,
    input  pix_t nbr_e,
    input  pix_t nbr_s,
    input  pix_t nbr_w,
    output logic flag
);

    logic [3:0][PIX_W-1:0] nbr;
    logic [3:0]            msb_gt;
    logic [3:0]            msb_eq;
    logic [3:0]            nbr_lsb;
    logic                  own_lsb;
    logic [3:0]            ge;

    assign nbr = {nbr_w, nbr_s, nbr_e, nbr_n};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            msb_gt  <= '0;
            msb_eq  <= '0;
            nbr_lsb <= '0;
            own_lsb <= 1'b0;
        end else if (en_msb) begin
            for (int k = 0; k < 4; k++) begin
                msb_gt[k]  <= own[1] & ~nbr[k][1];
                msb_eq[k]  <= own[1] ~^ nbr[k][1];
                nbr_lsb[k] <= nbr[k][0];
            end
            own_lsb <= own[0];
        end
    end

    // A tied MSB falls through to the LSB: own >= nbr unless own is 0 and nbr is 1.
    assign ge = msb_gt | (msb_eq & ~({4{~own_lsb}} & nbr_lsb));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flag <= 1'b0;
        end else if (en_lsb) begin
            flag <= &ge;
        end
    end

endmodule

// File: rtl/twobit_26x18_mesh.sv
// Torus local-maximum mesh: 26x18 two-bit frame store, one flag per pixel >= its N/E/S/W.
// Result 4 edges after a high rise, valid one cycle; dropping high or reset aborts, no backpressure.
module twobit_26x18_mesh
    import twobit_26x18_mesh_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    twobit_26x18_mesh_if.slave bus
);

    pix_t             store [N_PIX];
    pix_t             snap  [N_PIX];
    logic             high_d;
    logic [DEPTH-1:0] pipe_vld;
    logic [N_PIX-1:0] flag;
    logic             start;
    logic             busy;
    logic             wr_en;
    logic             snap_en;
    logic             en_msb;
    logic             en_lsb;
    logic             res_en;

    assign start   = bus.high & ~high_d;
    assign busy    = |pipe_vld;
    assign wr_en   = ~bus.high & ~busy & (int'(bus.row) < ROWS);
    assign snap_en = pipe_vld[0] & bus.high;
    assign en_msb  = pipe_vld[1] & bus.high;
    assign en_lsb  = pipe_vld[2] & bus.high;
    assign res_en  = pipe_vld[3] & bus.high;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int p = 0; p < N_PIX; p++) begin
                store[p] <= '0;
            end
        end else if (wr_en) begin
            for (int r = 0; r < ROWS; r++) begin
                if (int'(bus.row) == r) begin
                    for (int c = 0; c < COLS; c++) begin
                        store[r*COLS + c] <= bus.inp[c*PIX_W +: PIX_W];
                    end
                end
            end
        end
    end

    // The snapshot is only consumed behind pipe_vld, so it needs no reset.
    always_ff @(posedge clk) begin
        if (snap_en) begin
            snap <= store;
        end
    end

    // Each stage advances only while high stays up; a low sample empties the pipe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            high_d        <= 1'b0;
            pipe_vld      <= '0;
            bus.out       <= '0;
            bus.out_valid <= 1'b0;
        end else begin
            high_d        <= bus.high;
            pipe_vld[0]   <= start;
            pipe_vld[3:1] <= pipe_vld[2:0] & {3{bus.high}};
            bus.out_valid <= res_en;
            bus.out       <= res_en ? flag : '0;
        end
    end

    for (genvar p = 0; p < N_PIX; p++) begin : g_cell
        mesh_cell u_cell (
            .clk    (clk),
            .rst_n  (rst_n),
            .en_msb (en_msb),
            .en_lsb (en_lsb),
            .own    (snap[p]),
            .nbr_n  (snap[idx_n(p)]),
            .nbr_e  (snap[idx_e(p)]),
            .nbr_s  (snap[idx_s(p)]),
            .nbr_w  (snap[idx_w(p)]),
            .flag   (flag[p])
        );
    end

endmodule

// File: tb/tb_twobit_26x18_mesh.sv
// Directed bench for the torus local-maximum mesh with a frame-level reference model.
module tb_twobit_26x18_mesh;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    twobit_26x18_mesh_if bus ();

    twobit_26x18_mesh dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: frame contents, snapshot, and how many consecutive edges saw high=1.
    int           mem    [468];
    int           snap_m [468];
    int           run     = 0;
    logic         exp_vld = 1'b0;
    logic [467:0] exp_out = '0;

    function automatic logic [467:0] flags_of(input int m [468]);
        logic [467:0] f;
        int r, c, v;
        f = '0;
        for (int p = 0; p < 468; p++) begin
            r = p / 26;
            c = p % 26;
            v = m[p];
            f[p] = (v >= m[((r + 17) % 18) * 26 + c]) && (v >= m[((r + 1) % 18) * 26 + c]) &&
                   (v >= m[r * 26 + (c + 1) % 26]) && (v >= m[r * 26 + (c + 25) % 26]);
        end
        return f;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 468; i++) mem[i] = 0;
            run     = 0;
            exp_vld = 1'b0;
        end else begin
            if (!bus.high && int'(bus.row) < 18 && !(run >= 1 && run <= 4)) begin
                for (int c = 0; c < 26; c++)
                    mem[int'(bus.row) * 26 + c] = int'(bus.inp[2*c +: 2]);
            end
            run = bus.high ? ((run < 1000) ? run + 1 : run) : 0;
            if (run == 2) snap_m = mem;
            exp_vld = (run == 5);
            if (run == 5) exp_out = flags_of(snap_m);
        end
    end

    always @(negedge clk) begin
        n_cmp++;
        if (bus.out_valid !== exp_vld || bus.out !== (exp_vld ? exp_out : 468'd0)) begin
            n_bad++;
            $display("FAIL cycle t=%0t valid=%b want %b out=%h want %h", $time, bus.out_valid,
                     exp_vld, bus.out, exp_vld ? exp_out : 468'd0);
        end
    end

    task automatic check_int(input string name, input int act, input int req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0d (0x%h) want %0d (0x%h)", name, act, act, req, req);
        end
    endtask

    task automatic check_vec(input string name, input logic [467:0] act, input logic [467:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", name, act, req);
        end
    endtask

    task automatic load_row(input int r, input logic [51:0] v);
        @(negedge clk);
        bus.high = 1'b0;
        bus.row  = 5'(r);
        bus.inp  = v;
        @(negedge clk);
        bus.row  = 5'd31;
    endtask

    function automatic logic [51:0] pattern_row(input int v);
        logic [51:0] x;
        x = '0;
        for (int c = 0; c < 26; c++)
            x[2*c +: 2] = (c >= 22 && c % 2 == 0) ? 2'd3 : 2'(v);
        return x;
    endfunction

    // Raises high, holds it long past the result window, then drops it.
    task automatic run_compute(output logic [467:0] res, output int pulses);
        pulses = 0;
        res    = '0;
        @(negedge clk);
        bus.high = 1'b1;
        repeat (12) begin
            @(negedge clk);
            if (bus.out_valid) begin
                pulses++;
                res = bus.out;
            end
        end
        bus.high = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [467:0] res;
        logic [467:0] prev;
        int           pulses;
        int           seen;
        int           bad3;
        int           vals [6];
        int           v;
        vals = '{1, 0, 2, 2, 1, 3};

        bus.high = 1'b0;
        bus.row  = 5'd31;
        bus.inp  = '0;
        repeat (3) @(negedge clk);
        check_vec("reset_out", bus.out, '0);
        check_int("reset_valid", int'(bus.out_valid), 0);
        @(posedge clk);
        #2 rst_n = 1'b1;

        // Cleared store is uniform: every pixel flags.
        run_compute(res, pulses);
        check_int("uniform_pulses", pulses, 1);
        check_vec("uniform_all_ones", res, {468{1'b1}});
        check_vec("model_uniform", exp_out, {468{1'b1}});

        for (int r = 0; r < 18; r++) load_row(r, pattern_row(vals[r % 6]));
        run_compute(res, pulses);
        check_int("pattern_pulses", pulses, 1);
        bad3 = 0;
        for (int p = 0; p < 468; p++) begin
            v = (p % 26 >= 22 && (p % 26) % 2 == 0) ? 3 : vals[(p / 26) % 6];
            if (v == 3 && !res[p]) bad3++;
        end
        check_int("pattern_val3_flagged", bad3, 0);
        check_int("pattern_row5", int'(res[155:130]), 32'h03ff_ffff);
        check_int("pattern_row0", int'(res[25:0]), 32'h0140_0000);

        for (int r = 0; r < 18; r++) load_row(r, 52'd0);
        load_row(0, 52'h2);
        run_compute(res, pulses);
        check_int("peak_pulses", pulses, 1);
        check_int("peak_p0", int'(res[0]), 1);
        check_int("peak_nbrs", int'({res[442], res[26], res[25], res[1]}), 0);
        check_int("peak_ones", $countones(res), 464);
        check_int("model_peak_ones", $countones(exp_out), 464);
        prev = res;

        load_row(18, {52{1'b1}});
        run_compute(res, pulses);
        check_int("oor_pulses", pulses, 1);
        check_vec("oor_unchanged", res, prev);

        // Drop high so that the E2 edge samples it low.
        @(negedge clk);
        bus.high = 1'b1;
        @(negedge clk);
        @(negedge clk);
        bus.high = 1'b0;
        seen = 0;
        repeat (8) begin
            @(negedge clk);
            if (bus.out_valid || (|bus.out)) seen++;
        end
        check_int("abort_silent", seen, 0);

        // Reset lands between E2 and E3.
        @(negedge clk);
        bus.high = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        rst_n    = 1'b0;
        bus.high = 1'b0;
        seen = 0;
        repeat (3) begin
            @(negedge clk);
            if (bus.out_valid || (|bus.out)) seen++;
        end
        @(posedge clk);
        #2 rst_n = 1'b1;
        repeat (6) begin
            @(negedge clk);
            if (bus.out_valid || (|bus.out)) seen++;
        end
        check_int("reset_mid_silent", seen, 0);
        run_compute(res, pulses);
        check_int("post_reset_pulses", pulses, 1);
        check_vec("post_reset_all_ones", res, {468{1'b1}});

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/twobit_26x18_mesh.md
TWOBIT_26X18_MESH -- requirements
Module: twobit_26x18_mesh

Interface
REQ-001 Parameters: COLS=26, columns per row; ROWS=18, rows in frame; PIX_W=2, bits per pixel; N_PIX=468, pixels per frame.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 inp  input  52  one row of 26 two-bit pixels; column c at inp[2c+1:2c].
REQ-005 row  input  5  target row index for inp, valid 0..17.
REQ-006 high  input  1  0 = load phase; 1 = compute phase.
REQ-007 out  output  468  one flag bit per pixel, index p = row*26 + col.
REQ-008 out_valid  output  1  high for exactly the cycle in which out carries a result.

Function
REQ-009 Frame store: 468 two-bit registers, pixel p = row*26 + col.
REQ-010 Load: on a rising edge with high=0 and row<=17, the store SHALL write inp into row `row`, all 26 pixels; other rows unchanged.
REQ-011 Load: row values 18..31 SHALL be ignored, with no write.
REQ-012 Load: no writes SHALL occur while high=1 or while a computation is in flight.
REQ-013 Start: a computation SHALL start on the first rising edge where high=1 and high was 0 on the previous edge (rising-edge detect).
REQ-014 Neighbours: neighbours are on a torus.
  - N = (p-26) mod 468; S = (p+26) mod 468.
  - E = row*26 + (col+1) mod 26; W = row*26 + (col-1) mod 26.
REQ-015 Result: out[p]=1 iff value(p) >= value of each of N, E, S, W (unsigned 2-bit compare); else out[p]=0.
REQ-016 Pipeline: 4-cycle pipeline, starting at the start edge (E0).
  - E1: snapshot the store.
  - E2: MSB compare.
  - E3: LSB resolve.
  - E4: register out; out_valid=1 after E4.
REQ-017 Result window: out and out_valid SHALL hold for exactly one cycle; at E5 out returns to all-zero and out_valid to 0.
REQ-018 Idle: outside the result window, out SHALL be all-zero and out_valid 0.
REQ-019 Abort: if high falls to 0 before E4, the computation SHALL abort with no result cycle.
REQ-020 Held high: high held at 1 after a result SHALL NOT retrigger; a new high 0->1 transition is required.
REQ-021 Uniform frame: a uniform frame SHALL yield out = all ones.
REQ-022 Snapshot: the result SHALL depend only on the snapshot taken at E1.

Reset
REQ-023 On rst_n=0, immediately and independent of clk:
  - frame store cleared to 0;
  - pipeline flushed;
  - high edge-detect history cleared to 0;
  - out = 0 and out_valid = 0.
REQ-024 Reset asserted mid-computation SHALL cancel it with no result cycle.
REQ-025 After rst_n deasserts, operation SHALL resume on the next rising edge.

Structure
REQ-026 A shared package SHALL hold COLS, ROWS, PIX_W, N_PIX, the pixel type (2-bit unsigned) and the torus index functions for N, E, S, W.
REQ-027 Per-pixel compare SHALL be one sub-module, mesh_cell, instantiated 468 times via generate.
  - Inputs: own value and four neighbour values.
  - Output: one flag.
REQ-028 Top level SHALL contain the frame store, the row-write decode, the start edge detect and the 4-stage pipeline/valid shift register.

Verification
REQ-029 Reset check: apply reset, then set high=1 with no loads -> at E4 out = all ones, out_valid=1; at E5 out=0.
REQ-030 Row pattern, row values:
  - Rows r=0..17 hold per-row value v = {1,0,2,2,1,3}[r%6].
  - Row r: columns 0..21 = v; columns 22..25 alternate 3,v.
REQ-030a Row pattern, required response:
  - Every pixel of value 3 flags 1.
  - Every pixel in row 5 flags 1.
  - Every row-0 pixel of value 1 flags 0 (its N neighbour, row 17, has value 3).
REQ-031 Single peak: all pixels 0 except p=0 = 2 (row 0, col 0).
  - out[0]=1.
  - out[1], out[25], out[26], out[442] = 0.
  - All other bits = 1.
REQ-032 Out-of-range row: load row=18 with inp all 3s -> store unchanged (compute result equals the pre-load result).
REQ-033 Abort: raise high, drop it at E2 -> out_valid stays 0 and out stays 0.
REQ-034 Async reset: assert rst_n=0 between E2 and E3 -> out_valid never asserts; store reads back 0 (the next compute gives all ones).
